// File: rtl/fsbuf_pkg.sv
// fsbuf_pkg: buffer-state and FSM encodings plus default address map for the frame-buffer scheduler
package fsbuf_pkg;
    typedef enum logic [1:0] {
        BUF_FREE    = 2'd0,
        BUF_WRITING = 2'd1,
        BUF_READY   = 2'd2,
        BUF_READING = 2'd3
    } buf_st_e;
    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } fsm_st_e;
    localparam logic [31:0] DEF_BUF_BASE   = 32'h3F00_0000;
    localparam logic [31:0] DEF_BUF_STRIDE = 32'h0010_0000;
endpackage

// File: rtl/fsbuf_pick_free.sv
// fsbuf_pick_free: lowest-index FREE buffer priority encoder
// ports: states (2 bits per buffer, buffer i at [2i+1:2i]) -> idx (lowest FREE), found (any FREE)
module fsbuf_pick_free
    import fsbuf_pkg::*;
#(
    parameter int C_BUF_NUM   = 4,
    parameter int C_IDX_WIDTH = 3
) (
    input  logic [2*C_BUF_NUM-1:0] states,
    output logic [C_IDX_WIDTH-1:0] idx,
    output logic                   found
);
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = C_BUF_NUM - 1; i >= 0; i--) begin
            if (states[2*i +: 2] == BUF_FREE) begin
                idx   = C_IDX_WIDTH'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fsbuf_sched.sv
// fsbuf_sched: shares C_BUF_NUM frame buffers between a write DMA and a read DMA
// ports: clk, resetn (async, active low), soft_resetn (sync clear);
//        w_done -> w_valid/w_idx/w_addr (buffer being written);
//        r_req/r_done -> r_ack/r_valid/r_idx/r_addr (buffer being read);
//        frm_cnt/drop_cnt statistics; buf_state = 2 bits per buffer, buffer i at [2i+1:2i]
module fsbuf_sched
    import fsbuf_pkg::*;
#(
    parameter int                          C_BUF_NUM        = 4,
    parameter int                          C_IDX_WIDTH      = 3,
    parameter int                          C_BUF_ADDR_WIDTH = 32,
    parameter logic [C_BUF_ADDR_WIDTH-1:0] C_BUF_BASE       = C_BUF_ADDR_WIDTH'(DEF_BUF_BASE),
    parameter logic [C_BUF_ADDR_WIDTH-1:0] C_BUF_STRIDE     = C_BUF_ADDR_WIDTH'(DEF_BUF_STRIDE),
    parameter int                          C_CNT_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        soft_resetn,
    input  logic                        w_done,
    output logic                        w_valid,
    output logic [C_IDX_WIDTH-1:0]      w_idx,
    output logic [C_BUF_ADDR_WIDTH-1:0] w_addr,
    input  logic                        r_req,
    input  logic                        r_done,
    output logic                        r_ack,
    output logic                        r_valid,
    output logic [C_IDX_WIDTH-1:0]      r_idx,
    output logic [C_BUF_ADDR_WIDTH-1:0] r_addr,
    output logic [C_CNT_WIDTH-1:0]      frm_cnt,
    output logic [C_CNT_WIDTH-1:0]      drop_cnt,
    output logic [2*C_BUF_NUM-1:0]      buf_state
);
    localparam logic [2*C_BUF_NUM-1:0] BS_RST = (2*C_BUF_NUM)'(BUF_WRITING);

    fsm_st_e                  st_q, st_d;
    logic [2*C_BUF_NUM-1:0]   bs_q, bs_m, bs_d;
    logic [C_IDX_WIDTH-1:0]   w_idx_q, w_idx_d, r_idx_q, r_idx_d, rdy_idx, free_idx;
    logic                     r_valid_q, r_valid_d, r_ack_q, r_ack_d, rdy_found, free_found;
    logic [C_CNT_WIDTH-1:0]   frm_cnt_q, frm_cnt_d, drop_cnt_q, drop_cnt_d;

    // bs_m: state after writer completion and reader events, before a new writer buffer is chosen
    always_comb begin
        bs_m       = bs_q;
        r_idx_d    = r_idx_q;
        r_valid_d  = r_valid_q;
        r_ack_d    = 1'b0;
        frm_cnt_d  = frm_cnt_q;
        drop_cnt_d = drop_cnt_q;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        if (!soft_resetn) begin
            bs_m       = BS_RST;
            r_idx_d    = '0;
            r_valid_d  = 1'b0;
            frm_cnt_d  = '0;
            drop_cnt_d = '0;
        end else if (st_q == ST_RUN) begin
            if (w_done) begin
                frm_cnt_d = frm_cnt_q + C_CNT_WIDTH'(1);
                for (int i = 0; i < C_BUF_NUM; i++) begin
                    if (bs_q[2*i +: 2] == BUF_READY) begin
                        bs_m[2*i +: 2] = BUF_FREE;
                        drop_cnt_d     = drop_cnt_q + C_CNT_WIDTH'(1);
                    end
                    if (C_IDX_WIDTH'(i) == w_idx_q) bs_m[2*i +: 2] = BUF_READY;
                end
            end
            for (int i = C_BUF_NUM - 1; i >= 0; i--) begin
                if (bs_m[2*i +: 2] == BUF_READY) begin
                    rdy_found = 1'b1;
                    rdy_idx   = C_IDX_WIDTH'(i);
                end
            end
            // r_req takes priority over r_done: swapping in a new frame releases the old one anyway
            if (r_req) begin
                r_ack_d = 1'b1;
                if (rdy_found) begin
                    for (int i = 0; i < C_BUF_NUM; i++) begin
                        if (bs_m[2*i +: 2] == BUF_READING) bs_m[2*i +: 2] = BUF_FREE;
                        if (C_IDX_WIDTH'(i) == rdy_idx) bs_m[2*i +: 2] = BUF_READING;
                    end
                    r_idx_d   = rdy_idx;
                    r_valid_d = 1'b1;
                end
            end else if (r_done && r_valid_q) begin
                for (int i = 0; i < C_BUF_NUM; i++)
                    if (bs_m[2*i +: 2] == BUF_READING) bs_m[2*i +: 2] = BUF_FREE;
                r_valid_d = 1'b0;
            end
        end
    end

    fsbuf_pick_free #(
        .C_BUF_NUM   (C_BUF_NUM),
        .C_IDX_WIDTH (C_IDX_WIDTH)
    ) u_pick (
        .states (bs_m),
        .idx    (free_idx),
        .found  (free_found)
    );

    always_comb begin
        st_d    = soft_resetn ? ST_RUN : ST_HALT;
        bs_d    = bs_m;
        w_idx_d = soft_resetn ? w_idx_q : '0;
        if (soft_resetn && st_q == ST_RUN && w_done) begin
            w_idx_d = free_idx;
            for (int i = 0; i < C_BUF_NUM; i++)
                if (C_IDX_WIDTH'(i) == free_idx) bs_d[2*i +: 2] = BUF_WRITING;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q       <= ST_HALT;
            bs_q       <= BS_RST;
            w_idx_q    <= '0;
            r_idx_q    <= '0;
            r_valid_q  <= 1'b0;
            r_ack_q    <= 1'b0;
            frm_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            st_q       <= st_d;
            bs_q       <= bs_d;
            w_idx_q    <= w_idx_d;
            r_idx_q    <= r_idx_d;
            r_valid_q  <= r_valid_d;
            r_ack_q    <= r_ack_d;
            frm_cnt_q  <= frm_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // with three or more buffers a FREE one always exists when the writer completes
    always_ff @(posedge clk) begin
        if (resetn && soft_resetn && st_q == ST_RUN && w_done) assert (free_found);
    end

    assign w_valid   = st_q == ST_RUN;
    assign w_idx     = w_idx_q;
    assign w_addr    = C_BUF_BASE + C_BUF_ADDR_WIDTH'(w_idx_q) * C_BUF_STRIDE;
    assign r_ack     = r_ack_q;
    assign r_valid   = r_valid_q;
    assign r_idx     = r_idx_q;
    assign r_addr    = C_BUF_BASE + C_BUF_ADDR_WIDTH'(r_idx_q) * C_BUF_STRIDE;
    assign frm_cnt   = frm_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign buf_state = bs_q;
endmodule

// File: tb/tb_fsbuf_sched.sv
// tb_fsbuf_sched: directed vectors with a scoreboard queue for fsbuf_sched (4 buffers)
module tb_fsbuf_sched;
    typedef struct packed {
        logic        w_valid;
        logic [2:0]  w_idx;
        logic [31:0] w_addr;
        logic        r_ack;
        logic        r_valid;
        logic [2:0]  r_idx;
        logic [31:0] r_addr;
        logic [15:0] frm;
        logic [15:0] drop;
        logic [7:0]  bs;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn, soft_resetn, w_done, r_req, r_done;
    logic        w_valid, r_ack, r_valid;
    logic [2:0]  w_idx, r_idx;
    logic [31:0] w_addr, r_addr;
    logic [15:0] frm_cnt, drop_cnt;
    logic [7:0]  buf_state;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    fsbuf_sched dut (
        .clk         (clk),
        .resetn      (resetn),
        .soft_resetn (soft_resetn),
        .w_done      (w_done),
        .w_valid     (w_valid),
        .w_idx       (w_idx),
        .w_addr      (w_addr),
        .r_req       (r_req),
        .r_done      (r_done),
        .r_ack       (r_ack),
        .r_valid     (r_valid),
        .r_idx       (r_idx),
        .r_addr      (r_addr),
        .frm_cnt     (frm_cnt),
        .drop_cnt    (drop_cnt),
        .buf_state   (buf_state)
    );

    always #5 clk = ~clk;

    function automatic exp_t e(logic wv, int wi, logic ack, logic rv, int ri, int frm, int drop, logic [7:0] bs);
        exp_t x;
        x.w_valid = wv;
        x.w_idx   = 3'(wi);
        x.w_addr  = 32'h3F00_0000 + 32'(wi) * 32'h0010_0000;
        x.r_ack   = ack;
        x.r_valid = rv;
        x.r_idx   = 3'(ri);
        x.r_addr  = 32'h3F00_0000 + 32'(ri) * 32'h0010_0000;
        x.frm     = 16'(frm);
        x.drop    = 16'(drop);
        x.bs      = bs;
        return x;
    endfunction

    function automatic string fmt(exp_t x);
        return $sformatf("wv=%0b wi=%0d wa=%h ack=%0b rv=%0b ri=%0d ra=%h frm=%0d drop=%0d bs=%h",
                         x.w_valid, x.w_idx, x.w_addr, x.r_ack, x.r_valid, x.r_idx, x.r_addr, x.frm, x.drop, x.bs);
    endfunction

    task automatic vec(input string nm, input logic sr, input logic wd, input logic rq, input logic rd, input exp_t x);
        @(negedge clk);
        soft_resetn = sr;
        w_done      = wd;
        r_req       = rq;
        r_done      = rd;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    // monitor: the DUT presents a new registered state after each clock edge or an async reset
    always @(posedge clk or negedge resetn) begin
        exp_t  g, x;
        string nm;
        #1;
        if (exp_q.size() > 0) begin
            x  = exp_q.pop_front();
            nm = name_q.pop_front();
            g  = {w_valid, w_idx, w_addr, r_ack, r_valid, r_idx, r_addr, frm_cnt, drop_cnt, buf_state};
            n_vec++;
            if (g !== x) begin
                n_bad++;
                $display("FAIL %s: got %s / expected %s", nm, fmt(g), fmt(x));
            end
        end
    end

    initial begin
        resetn      = 1'b0;
        soft_resetn = 1'b0;
        w_done      = 1'b0;
        r_req       = 1'b0;
        r_done      = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        vec("halt",        0, 0, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 8'h01));
        vec("halt_ignore", 0, 1, 1, 1, e(0, 0, 0, 0, 0, 0, 0, 8'h01));
        vec("run",         1, 1, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 8'h01));
        vec("wdone1",      1, 1, 0, 0, e(1, 1, 0, 0, 0, 1, 0, 8'h06));
        vec("rreq1",       1, 0, 1, 0, e(1, 1, 1, 1, 0, 1, 0, 8'h07));
        vec("wdone2",      1, 1, 0, 0, e(1, 2, 0, 1, 0, 2, 0, 8'h1B));
        vec("wdone3_drop", 1, 1, 0, 0, e(1, 1, 0, 1, 0, 3, 1, 8'h27));
        vec("rreq2",       1, 0, 1, 0, e(1, 1, 1, 1, 2, 3, 1, 8'h34));
        vec("wd_rq1",      1, 1, 1, 0, e(1, 0, 1, 1, 1, 4, 1, 8'h0D));
        vec("wdone4",      1, 1, 0, 0, e(1, 2, 0, 1, 1, 5, 1, 8'h1E));
        vec("rreq3",       1, 0, 1, 0, e(1, 2, 1, 1, 0, 5, 1, 8'h13));
        vec("wd_rq2",      1, 1, 1, 0, e(1, 0, 1, 1, 2, 6, 1, 8'h31));
        vec("rreq_none",   1, 0, 1, 0, e(1, 0, 1, 1, 2, 6, 1, 8'h31));
        vec("rdone",       1, 0, 0, 1, e(1, 0, 0, 0, 2, 6, 1, 8'h01));
        vec("rdone_ign",   1, 0, 0, 1, e(1, 0, 0, 0, 2, 6, 1, 8'h01));
        vec("rreq_empty",  1, 0, 1, 0, e(1, 0, 1, 0, 2, 6, 1, 8'h01));
        vec("wdone5",      1, 1, 0, 0, e(1, 1, 0, 0, 2, 7, 1, 8'h06));
        vec("wdone6_drop", 1, 1, 0, 0, e(1, 0, 0, 0, 2, 8, 2, 8'h09));
        vec("rreq4",       1, 0, 1, 0, e(1, 0, 1, 1, 1, 8, 2, 8'h0D));
        vec("wdone7",      1, 1, 0, 0, e(1, 2, 0, 1, 1, 9, 2, 8'h1E));
        vec("rd_rq",       1, 0, 1, 1, e(1, 2, 1, 1, 0, 9, 2, 8'h13));
        vec("soft_rst",    0, 1, 1, 0, e(0, 0, 0, 0, 0, 0, 0, 8'h01));
        vec("soft_hold",   0, 1, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 8'h01));
        vec("rerun",       1, 0, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 8'h01));
        vec("wdone8",      1, 1, 0, 0, e(1, 1, 0, 0, 0, 1, 0, 8'h06));
        vec("rreq5",       1, 0, 1, 0, e(1, 1, 1, 1, 0, 1, 0, 8'h07));
        @(posedge clk);
        #3;
        exp_q.push_back(e(0, 0, 0, 0, 0, 0, 0, 8'h01));
        name_q.push_back("async_rst");
        resetn = 1'b0;
        vec("async_hold",  1, 1, 1, 0, e(0, 0, 0, 0, 0, 0, 0, 8'h01));
        @(posedge clk);
        #2;
        resetn = 1'b1;
        vec("async_run",   1, 0, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 8'h01));
        vec("wdone9",      1, 1, 0, 0, e(1, 1, 0, 0, 0, 1, 0, 8'h06));
        @(negedge clk);
        w_done = 1'b0;
        r_req  = 1'b0;
        r_done = 1'b0;
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
